// File: rtl/clkdiv_pkg.sv
// ---------------------------------------------------------------------------
// clkdiv_pkg
// Shared definitions for the configurable clock divider and its configuration
// sequencer: FSM state encoding, counter width and the default quiet/settle
// window lengths. The divider bench imports the same values.
// ---------------------------------------------------------------------------
package clkdiv_pkg;

    // Sequencer state encoding. Fixed values so that benches and debug
    // tooling can decode the state register directly.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_GATE   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_SETTLE = 3'd4
    } seq_state_t;

    // Window counter width. Both windows are limited to 1..15 cycles, so the
    // counter never needs to wrap.
    localparam int CNT_W = 4;

    localparam int DEF_QUIET_CYCLES  = 2;
    localparam int DEF_SETTLE_CYCLES = 2;

endpackage : clkdiv_pkg

// File: rtl/clkdiv_cfg_seq.sv
// ---------------------------------------------------------------------------
// clkdiv_cfg_seq
// Configuration sequencer in front of the clock divider. Accepts ratio change
// requests over a valid/ready handshake and, when the divider is running,
// drops its enable, waits a quiet window, loads the new ratio, waits a settle
// window and re-enables. The divider therefore never sees its ratio change
// while it is enabled. While the divider is idle, a new ratio is loaded
// directly.
//
// Ports:
//   I_ref_clk    in   1      reference clock (shared with the divider)
//   I_rst_n      in   1      asynchronous active-low reset
//   I_enable     in   1      global divider enable from the register file
//   I_cfg_ratio  in   RATIO  requested divide ratio
//   I_cfg_valid  in   1      request valid
//   o_cfg_ready  out  1      request can be accepted (IDLE or RUN)
//   o_div_ratio  out  RATIO  ratio driven to the divider (registered)
//   o_clk_en     out  1      enable driven to the divider (registered)
//   o_busy       out  1      gated change sequence in progress (registered)
//   o_ratio_upd  out  1      one-cycle pulse alongside each new o_div_ratio
// ---------------------------------------------------------------------------
module clkdiv_cfg_seq
    import clkdiv_pkg::*;
#(
    parameter int RATIO         = 8,
    parameter int DEFAULT_RATIO = 8,
    parameter int QUIET_CYCLES  = DEF_QUIET_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             I_ref_clk,
    input  logic             I_rst_n,
    input  logic             I_enable,
    input  logic [RATIO-1:0] I_cfg_ratio,
    input  logic             I_cfg_valid,
    output logic             o_cfg_ready,
    output logic [RATIO-1:0] o_div_ratio,
    output logic             o_clk_en,
    output logic             o_busy,
    output logic             o_ratio_upd
);

    localparam logic [RATIO-1:0] DEF_RATIO   = RATIO'(DEFAULT_RATIO);
    // The counter starts at 0 on entry to a window, so a window of N cycles
    // ends when the counter holds N-1.
    localparam logic [CNT_W-1:0] QUIET_LAST  = CNT_W'(QUIET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    seq_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [RATIO-1:0] r_pending;
    logic [RATIO-1:0] r_div_ratio;
    logic             r_clk_en;
    logic             r_busy;
    logic             r_ratio_upd;

    logic             w_ready;
    logic             w_accept;

    // Ready is a pure decode of the state register so it carries no
    // combinational path from the request inputs.
    assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_accept = I_cfg_valid && w_ready;

    always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pending   <= '0;
            r_div_ratio <= DEF_RATIO;
            r_clk_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_ratio_upd <= 1'b0;
        end else begin
            r_ratio_upd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Divider is already disabled: load directly. A pending
                    // enable is picked up on the following edge.
                    if (w_accept) begin
                        r_div_ratio <= I_cfg_ratio;
                        r_ratio_upd <= 1'b1;
                    end else if (I_enable) begin
                        r_state  <= ST_RUN;
                        r_clk_en <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Disable wins; a request arriving in the same cycle is
                    // dropped.
                    if (!I_enable) begin
                        r_state  <= ST_IDLE;
                        r_clk_en <= 1'b0;
                    end else if (w_accept && (I_cfg_ratio != r_div_ratio)) begin
                        r_pending <= I_cfg_ratio;
                        r_clk_en  <= 1'b0;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_GATE;
                    end
                end
                ST_GATE: begin
                    if (r_cnt == QUIET_LAST) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_div_ratio <= r_pending;
                    r_ratio_upd <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // I_enable is only consulted here, so dropping it mid
                    // sequence still lets the new ratio land.
                    if (r_cnt == SETTLE_LAST) begin
                        r_busy <= 1'b0;
                        if (I_enable) begin
                            r_state  <= ST_RUN;
                            r_clk_en <= 1'b1;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_clk_en <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign o_cfg_ready = w_ready;
    assign o_div_ratio = r_div_ratio;
    assign o_clk_en    = r_clk_en;
    assign o_busy      = r_busy;
    assign o_ratio_upd = r_ratio_upd;

endmodule : clkdiv_cfg_seq

// File: tb/tb_clkdiv_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_clkdiv_cfg_seq
// Directed bench for clkdiv_cfg_seq. Each request that should change the
// divider ratio pushes the expected ratio into a queue; a monitor pops one
// entry per o_ratio_upd pulse and compares o_div_ratio. Cycle-by-cycle
// expectations for enable/busy/ready are hand-computed from the quiet and
// settle window lengths.
// ---------------------------------------------------------------------------
module tb_clkdiv_cfg_seq;

    localparam int RATIO = 8;
    localparam int DEF_R = 8;
    localparam int Q     = 2;
    localparam int S     = 2;
    // Cycles after the accept cycle at which each event becomes visible.
    localparam int N_RATIO = Q + 2;
    localparam int N_REEN  = Q + S + 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [RATIO-1:0] cfg_ratio = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [RATIO-1:0] div_ratio;
    logic             clk_en;
    logic             busy;
    logic             ratio_upd;

    int               errors = 0;
    int               checks = 0;
    logic [RATIO-1:0] exp_q[$];
    logic [RATIO-1:0] mon_exp;

    clkdiv_cfg_seq #(
        .RATIO         (RATIO),
        .DEFAULT_RATIO (DEF_R),
        .QUIET_CYCLES  (Q),
        .SETTLE_CYCLES (S)
    ) dut (
        .I_ref_clk   (clk),
        .I_rst_n     (rst_n),
        .I_enable    (en),
        .I_cfg_ratio (cfg_ratio),
        .I_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .o_div_ratio (div_ratio),
        .o_clk_en    (clk_en),
        .o_busy      (busy),
        .o_ratio_upd (ratio_upd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; push the ratio if an update
    // pulse is expected for it.
    task automatic req(input logic [RATIO-1:0] r, input bit expect_upd);
        if (expect_upd) exp_q.push_back(r);
        cfg_ratio = r;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Monitor: every update pulse must match the next expected ratio.
    always @(negedge clk) begin
        if (rst_n && ratio_upd) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL upd_unexpected: got pulse with ratio %0d expected no pulse (t=%0t)",
                         div_ratio, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("upd_ratio", 32'(div_ratio), 32'(mon_exp));
            end
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_ratio", 32'(div_ratio), DEF_R);
        chk("rst_clk_en", 32'(clk_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        chk("rst_upd", 32'(ratio_upd), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Enable from IDLE: clk_en rises one cycle later
        en = 1'b1;
        chk("en_before", 32'(clk_en), 0);
        tick();
        chk("en_after", 32'(clk_en), 1);
        chk("run_ready", 32'(cfg_ready), 1);

        // Gated change 8 -> 6 from RUN
        req(8'd6, 1'b1);
        for (int n = 1; n <= N_REEN + 1; n++) begin
            chk($sformatf("chg6_clk_en_n%0d", n), 32'(clk_en), (n >= N_REEN) ? 1 : 0);
            chk($sformatf("chg6_busy_n%0d", n), 32'(busy), (n >= N_REEN) ? 0 : 1);
            chk($sformatf("chg6_ready_n%0d", n), 32'(cfg_ready), (n >= N_REEN) ? 1 : 0);
            chk($sformatf("chg6_ratio_n%0d", n), 32'(div_ratio), (n >= N_RATIO) ? 6 : 8);
            tick();
        end

        // Same-ratio request in RUN is a no-op
        req(8'd6, 1'b0);
        for (int n = 1; n <= 3; n++) begin
            chk($sformatf("same6_clk_en_n%0d", n), 32'(clk_en), 1);
            chk($sformatf("same6_busy_n%0d", n), 32'(busy), 0);
            tick();
        end

        // Drop to IDLE, then direct loads including bypass value 1
        en = 1'b0;
        tick();
        chk("idle_clk_en", 32'(clk_en), 0);
        req(8'd3, 1'b1);
        chk("idle_ratio3", 32'(div_ratio), 3);
        chk("idle_upd3", 32'(ratio_upd), 1);
        chk("idle_clk_en3", 32'(clk_en), 0);
        tick();
        chk("idle_upd3_end", 32'(ratio_upd), 0);
        req(8'd1, 1'b1);
        chk("idle_ratio1", 32'(div_ratio), 1);
        chk("idle_busy1", 32'(busy), 0);
        tick();

        // Request 5 from RUN, drop enable during GATE: ends in IDLE
        en = 1'b1;
        tick();
        chk("run2_clk_en", 32'(clk_en), 1);
        req(8'd5, 1'b1);
        en = 1'b0;
        for (int n = 1; n <= N_REEN + 1; n++) begin
            chk($sformatf("chg5_clk_en_n%0d", n), 32'(clk_en), 0);
            chk($sformatf("chg5_busy_n%0d", n), 32'(busy), (n >= N_REEN) ? 0 : 1);
            chk($sformatf("chg5_ready_n%0d", n), 32'(cfg_ready), (n >= N_REEN) ? 1 : 0);
            chk($sformatf("chg5_ratio_n%0d", n), 32'(div_ratio), (n >= N_RATIO) ? 5 : 1);
            tick();
        end

        // Reset asserted during SETTLE
        en = 1'b1;
        tick();
        req(8'd9, 1'b1);
        for (int n = 1; n < N_RATIO + 1; n++) tick();
        chk("settle_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_ratio", 32'(div_ratio), DEF_R);
        chk("arst_clk_en", 32'(clk_en), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(cfg_ready), 1);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Reset asserted during GATE: pending ratio must be discarded
        en = 1'b1;
        tick();
        req(8'd7, 1'b0);
        tick();
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        chk("grst_clk_en", 32'(clk_en), 0);
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < Q + S + 4; n++) tick();
        chk("grst_ratio", 32'(div_ratio), DEF_R);
        chk("grst_busy", 32'(busy), 0);

        // Every expected update must have been observed
        tick();
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_clkdiv_cfg_seq
